data_memory: RTL

Word-organised data memory and memory-mapped peripheral responder on the CPU data port. It services the CPU's `data_addr` / `data_out` / `mem_read` / `mem_write` requests and returns read data on `data_in` in the same cycle, as single-cycle execution requires. It also hosts a free-running timer with a compare interrupt and a sticky access-fault latch, all in a small MMIO window.

---
 rtl/data_memory.sv | 128 ++++++++++++
 1 files changed

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word RAM plus timer/status MMIO responder on the CPU data port
module data_memory #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] data_in,
    output logic        fault,
    output logic        timer_irq
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_LIMIT = 32'(DEPTH * 4);

    localparam logic [2:0] OFF_COUNT  = 3'd0;
    localparam logic [2:0] OFF_CMP    = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_FADDR  = 3'd3;
    localparam logic [2:0] OFF_ACCESS = 3'd4;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_timer_count;
    logic [31:0]   r_timer_cmp;
    logic [31:0]   r_fault_addr;
    logic [31:0]   r_access_count;
    logic          r_fault;
    logic          r_timer_irq;

    logic          w_access;
    logic          w_is_ram;
    logic          w_is_mmio;
    logic          w_misalign;
    logic          w_mmio_unused;
    logic          w_fault_acc;
    logic          w_ok;
    logic          w_ram_ok;
    logic          w_mmio_wr;
    logic [2:0]    w_off;
    logic [AW-1:0] w_idx;
    logic          w_clr_fault;
    logic          w_clr_irq;
    logic [31:0]   w_rd_data;

    assign w_access      = mem_read || mem_write;
    assign w_is_ram      = data_addr < RAM_LIMIT;
    assign w_is_mmio     = data_addr[31:5] == MMIO_BASE[31:5];
    assign w_misalign    = |data_addr[1:0];
    assign w_off         = data_addr[4:2];
    assign w_idx         = data_addr[AW+1:2];
    assign w_mmio_unused = w_is_mmio && (w_off > OFF_ACCESS);
    assign w_fault_acc   = w_access && (w_misalign || !(w_is_ram || w_is_mmio) || w_mmio_unused);
    assign w_ok          = w_access && !w_fault_acc;
    assign w_ram_ok      = w_ok && w_is_ram;
    assign w_mmio_wr     = w_ok && w_is_mmio && mem_write;
    assign w_clr_fault   = w_mmio_wr && (w_off == OFF_STATUS) && data_out[0];
    assign w_clr_irq     = w_mmio_wr && (w_off == OFF_STATUS) && data_out[1];

    // Zero-latency read mux; faulting or idle cycles return zero.
    always_comb begin
        w_rd_data = 32'h0;
        if (mem_read && !w_fault_acc) begin
            if (w_is_ram) begin
                w_rd_data = r_mem[w_idx];
            end else begin
                case (w_off)
                    OFF_COUNT:  w_rd_data = r_timer_count;
                    OFF_CMP:    w_rd_data = r_timer_cmp;
                    OFF_STATUS: w_rd_data = {30'h0, r_timer_irq, r_fault};
                    OFF_FADDR:  w_rd_data = r_fault_addr;
                    OFF_ACCESS: w_rd_data = r_access_count;
                    default:    w_rd_data = 32'h0;
                endcase
            end
        end
    end

    assign data_in   = w_rd_data;
    assign fault     = r_fault;
    assign timer_irq = r_timer_irq;

    // RAM array: no reset, write is suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && w_ram_ok && mem_write) begin
            r_mem[w_idx] <= data_out;
        end
    end

    // Timer, compare, status flags, fault address and access counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer_count  <= 32'h0;
            r_timer_cmp    <= 32'hFFFF_FFFF;
            r_fault_addr   <= 32'h0;
            r_access_count <= 32'h0;
            r_fault        <= 1'b0;
            r_timer_irq    <= 1'b0;
        end else begin
            if (w_mmio_wr && (w_off == OFF_COUNT)) begin
                r_timer_count <= data_out;
            end else begin
                r_timer_count <= r_timer_count + 32'h1;
            end

            if (w_mmio_wr && (w_off == OFF_CMP)) begin
                r_timer_cmp <= data_out;
            end

            // Set beats a same-cycle W1C clear.
            r_timer_irq <= (r_timer_count == r_timer_cmp) || (r_timer_irq && !w_clr_irq);
            r_fault     <= w_fault_acc || (r_fault && !w_clr_fault);

            // Keep the first fault address unless the flag is being cleared now.
            if (w_fault_acc && (!r_fault || w_clr_fault)) begin
                r_fault_addr <= data_addr;
            end

            if (w_ram_ok && (r_access_count != 32'hFFFF_FFFF)) begin
                r_access_count <= r_access_count + 32'h1;
            end
        end
    end

endmodule
